// File: rtl/cell_alloc_mgr_pkg.sv
// Shared types and width helpers for the cell allocation manager.
// Holds the FSM encoding and a minimum-1-bit clog2 used to size ID and pointer fields.
package cell_alloc_mgr_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cell_alloc_mgr_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr; purely combinational.
// No backpressure of its own; an empty request vector yields a zero grant.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cell_alloc_mgr.sv
// Cell free-list manager: zero-latency alloc grant, round-robin free ports, headroom for high prio.
// Frees are accepted one per cycle via one-hot free_ready; grants stop when the list is empty.
module cell_alloc_mgr
  import cell_alloc_mgr_pkg::*;
#(
  parameter int CELL_NUM       = 64,
  parameter int FREE_PORT_NUM  = 2,
  parameter int DROP_THRESH    = 2,
  parameter int INTENSE_THRESH = 32,
  parameter int CELL_ID_WIDTH  = width_of(CELL_NUM),
  parameter int COUNT_WIDTH    = $clog2(CELL_NUM + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  output logic                                   init_done,
  input  logic                                   alloc_req,
  input  logic                                   alloc_prio,
  output logic                                   alloc_grant,
  output logic [CELL_ID_WIDTH-1:0]               alloc_cell_id,
  output logic                                   alloc_intense,
  input  logic [FREE_PORT_NUM-1:0]               free_valid,
  output logic [FREE_PORT_NUM-1:0]               free_ready,
  input  logic [FREE_PORT_NUM*CELL_ID_WIDTH-1:0] free_cell_id,
  output logic [COUNT_WIDTH-1:0]                 free_count,
  output logic                                   err_free,
  output logic [CELL_ID_WIDTH-1:0]               err_cell_id,
  output logic [15:0]                            err_count
);

  localparam int PTR_W = width_of(FREE_PORT_NUM);

  state_t                   state, state_nxt;
  logic [CELL_ID_WIDTH-1:0] list [CELL_NUM];
  logic [CELL_NUM-1:0]      bitmap;
  logic [CELL_ID_WIDTH-1:0] head, tail;
  logic [COUNT_WIDTH-1:0]   init_idx;
  logic [PTR_W-1:0]         rr_ptr, win_idx, rr_nxt;
  logic [CELL_ID_WIDTH-1:0] free_id;
  logic                     run, init_last, free_acc, free_in_range, free_good;

  function automatic logic [CELL_ID_WIDTH-1:0] wrap_inc(input logic [CELL_ID_WIDTH-1:0] p);
    return (int'(p) == CELL_NUM - 1) ? '0 : p + 1'b1;
  endfunction

  assign run       = (state == ST_RUN);
  assign init_last = (init_idx == COUNT_WIDTH'(CELL_NUM));
  assign init_done = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_last) state_nxt = ST_RUN;
  end

  // Prio traffic may dip into the last DROP_THRESH cells; nobody can take from an empty list.
  assign alloc_grant   = run & alloc_req & (free_count != '0) &
                         (alloc_prio | (int'(free_count) > DROP_THRESH));
  assign alloc_cell_id = run ? list[head] : '0;
  assign alloc_intense = run & (int'(free_count) <= INTENSE_THRESH);

  rr_arbiter #(.N(FREE_PORT_NUM), .PW(PTR_W)) u_arb (
    .req (free_valid & {FREE_PORT_NUM{run}}),
    .ptr (rr_ptr),
    .gnt (free_ready)
  );

  always_comb begin
    win_idx = '0;
    free_id = '0;
    for (int i = 0; i < FREE_PORT_NUM; i++) begin
      if (free_ready[i]) begin
        win_idx = PTR_W'(i);
        free_id = free_cell_id[i*CELL_ID_WIDTH +: CELL_ID_WIDTH];
      end
    end
  end

  assign free_acc      = |free_ready;
  assign free_in_range = (int'(free_id) < CELL_NUM);
  // A good free must name a cell currently marked allocated; anything else is dropped as an error.
  assign free_good     = free_acc & free_in_range & bitmap[free_id];
  assign rr_nxt        = (int'(win_idx) == FREE_PORT_NUM - 1) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_idx    <= '0;
      head        <= '0;
      tail        <= '0;
      free_count  <= '0;
      bitmap      <= '0;
      rr_ptr      <= '0;
      err_free    <= 1'b0;
      err_cell_id <= '0;
      err_count   <= '0;
    end else begin
      err_free <= 1'b0;
      if (!run) begin
        tail <= '0;
        if (!init_last) init_idx   <= init_idx + 1'b1;
        else            free_count <= COUNT_WIDTH'(CELL_NUM);
      end else begin
        if (alloc_grant) begin
          head                  <= wrap_inc(head);
          bitmap[alloc_cell_id] <= 1'b1;
        end
        if (free_acc) begin
          rr_ptr <= rr_nxt;
          if (free_good) begin
            tail            <= wrap_inc(tail);
            bitmap[free_id] <= 1'b0;
          end else begin
            err_free    <= 1'b1;
            err_cell_id <= free_id;
            if (err_count != 16'hFFFF) err_count <= err_count + 1'b1;
          end
        end
        if (free_good && !alloc_grant)      free_count <= free_count + 1'b1;
        else if (!free_good && alloc_grant) free_count <= free_count - 1'b1;
      end
    end
  end

  // Storage only, no reset: INIT rewrites every entry before any read can matter.
  always_ff @(posedge clk) begin
    if (!run && !init_last) list[CELL_ID_WIDTH'(init_idx)] <= CELL_ID_WIDTH'(init_idx);
    else if (run && free_good) list[tail] <= free_id;
  end

endmodule

// File: tb/tb_cell_alloc_mgr.sv
// Directed bench for cell_alloc_mgr with a free-list / bitmap / round-robin reference model.
module tb_cell_alloc_mgr;

  localparam int CN = 64;
  localparam int W  = 6;
  localparam int CW = 7;
  localparam int N  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          init_done, alloc_req, alloc_prio, alloc_grant, alloc_intense, err_free;
  logic [W-1:0]  alloc_cell_id, err_cell_id;
  logic [N-1:0]  free_valid, free_ready;
  logic [N*W-1:0] free_cell_id;
  logic [CW-1:0] free_count;
  logic [15:0]   err_count;

  logic          c_init_done, c_grant, c_intense, c_err_free;
  logic [6:0]    c_cell_id, c_err_cell_id, c_free_count;
  logic [N-1:0]  c_free_valid, c_free_ready;
  logic [13:0]   c_free_cell_id;
  logic [15:0]   c_err_count;

  always #5 clk = ~clk;

  cell_alloc_mgr u_dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .alloc_req(alloc_req), .alloc_prio(alloc_prio), .alloc_grant(alloc_grant),
    .alloc_cell_id(alloc_cell_id), .alloc_intense(alloc_intense),
    .free_valid(free_valid), .free_ready(free_ready), .free_cell_id(free_cell_id),
    .free_count(free_count), .err_free(err_free), .err_cell_id(err_cell_id),
    .err_count(err_count)
  );

  cell_alloc_mgr #(.CELL_NUM(100)) u_dut100 (
    .clk(clk), .rst_n(rst_n), .init_done(c_init_done),
    .alloc_req(1'b0), .alloc_prio(1'b0), .alloc_grant(c_grant),
    .alloc_cell_id(c_cell_id), .alloc_intense(c_intense),
    .free_valid(c_free_valid), .free_ready(c_free_ready), .free_cell_id(c_free_cell_id),
    .free_count(c_free_count), .err_free(c_err_free), .err_cell_id(c_err_cell_id),
    .err_count(c_err_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int mq[$];
  bit mbm[CN];
  int mcnt, mrr, merr_cnt, merr_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < CN; i++) begin
      mq.push_back(i);
      mbm[i] = 1'b0;
    end
    mcnt = CN; mrr = 0; merr_cnt = 0; merr_id = 0;
  endtask

  // One clock of stimulus; expectations come from the model, outputs sampled off the edge.
  task automatic cyc(input bit req, input bit prio, input bit [1:0] fv, input int id0, input int id1);
    bit exp_g, exp_err, fgood;
    int eid, win, fid, p;
    alloc_req    = req;
    alloc_prio   = prio;
    free_valid   = fv;
    free_cell_id = {W'(id1), W'(id0)};
    #1;
    exp_g = req && (mcnt != 0) && (prio || mcnt > 2);
    chk("alloc_grant", alloc_grant, exp_g);
    chk("alloc_intense", alloc_intense, (mcnt <= 32));
    if (exp_g) begin
      eid = mq.pop_front();
      chk("alloc_cell_id", alloc_cell_id, eid);
      mbm[eid] = 1'b1;
    end
    win = -1;
    for (int k = 0; k < N; k++) begin
      p = (mrr + k) % N;
      if (win < 0 && fv[p]) win = p;
    end
    chk("free_ready", free_ready, (win < 0) ? 0 : (1 << win));
    exp_err = 1'b0;
    fgood   = 1'b0;
    if (win >= 0) begin
      mrr = (win + 1) % N;
      fid = (win == 1) ? id1 : id0;
      if (fid < CN && mbm[fid]) begin
        mbm[fid] = 1'b0;
        mq.push_back(fid);
        fgood = 1'b1;
      end else begin
        exp_err  = 1'b1;
        merr_id  = fid;
        merr_cnt = merr_cnt + 1;
      end
    end
    mcnt = mcnt + int'(fgood) - int'(exp_g);
    @(posedge clk); #1;
    chk("free_count", free_count, mcnt);
    chk("err_free", err_free, exp_err);
    chk("err_cell_id", err_cell_id, merr_id);
    chk("err_count", err_count, merr_cnt);
  endtask

  task automatic wait_init(input int expect_cycles);
    int  cnt;
    bit  leak;
    cnt  = 0;
    leak = 1'b0;
    while (!init_done && cnt < 300) begin
      if (alloc_grant || free_ready != '0) leak = 1'b1;
      @(posedge clk); #1;
      cnt++;
    end
    chk("init_latency", cnt, expect_cycles);
    chk("no_grant_in_init", leak, 0);
    alloc_req  = 1'b0;
    free_valid = '0;
    chk("init_free_count", free_count, CN);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; alloc_req = 1'b1; alloc_prio = 1'b1; free_valid = 2'b11;
    free_cell_id = '0; c_free_valid = '0; c_free_cell_id = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_free_count", free_count, 0);
    chk("rst_grant", alloc_grant, 0);
    chk("rst_cell_id", alloc_cell_id, 0);
    chk("rst_ready", free_ready, 0);
    chk("rst_intense", alloc_intense, 0);
    chk("rst_err_free", err_free, 0);
    chk("rst_err_count", err_count, 0);

    rst_n = 1'b1;
    wait_init(CN + 1);
    chk("idle_intense", alloc_intense, 0);
    model_reset();

    // Drain at low prio down to the headroom, then prio takes the last two cells.
    for (int i = 0; i < 63; i++) cyc(1, 0, 2'b00, 0, 0);
    for (int i = 0; i < 3; i++)  cyc(1, 1, 2'b00, 0, 0);

    // Both ports valid: accepts alternate; then a single port accepted every cycle.
    for (int k = 0; k < 6; k++) cyc(0, 0, 2'b11, 10 + 2*k, 11 + 2*k);
    for (int k = 0; k < 4; k++) cyc(0, 0, 2'b10, 0, 30 + k);

    // Same-cycle alloc and free at count 10; freed ID 40 comes back on the 10th later alloc.
    cyc(1, 0, 2'b01, 40, 0);
    for (int k = 0; k < 10; k++) cyc(1, 1, 2'b00, 0, 0);

    // Legal free of 5, then a double free of 5, then the error pulse must clear.
    cyc(0, 0, 2'b01, 5, 0);
    cyc(0, 0, 2'b01, 5, 0);
    cyc(0, 0, 2'b00, 0, 0);

    // Async reset mid-operation.
    alloc_req = 1'b1; alloc_prio = 1'b1; free_valid = 2'b11;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_init_done", init_done, 0);
    chk("async_grant", alloc_grant, 0);
    chk("async_ready", free_ready, 0);
    chk("async_free_count", free_count, 0);
    chk("async_err_count", err_count, 0);
    chk("async_intense", alloc_intense, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    alloc_req = 1'b0; free_valid = '0;
    wait_init(CN + 1);
    model_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 2'b00, 0, 0);

    // CELL_NUM=100 instance: unallocated ID 5 and out-of-range ID 120.
    n = 0;
    while (!c_init_done && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("c100_init_done", c_init_done, 1);
    chk("c100_free_count", c_free_count, 100);
    c_free_valid = 2'b01; c_free_cell_id = {7'd0, 7'd5};
    #1;
    chk("c100_ready", c_free_ready, 2'b01);
    @(posedge clk); #1;
    chk("c100_err_free_a", c_err_free, 1);
    chk("c100_err_id_a", c_err_cell_id, 5);
    chk("c100_err_cnt_a", c_err_count, 1);
    c_free_cell_id = {7'd0, 7'd120};
    @(posedge clk); #1;
    c_free_valid = '0;
    chk("c100_err_id_b", c_err_cell_id, 120);
    chk("c100_err_cnt_b", c_err_count, 2);
    chk("c100_count_kept", c_free_count, 100);
    @(posedge clk); #1;
    chk("c100_err_pulse", c_err_free, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
